// File: rtl/dehaze_frame_sequencer.sv
// Frame sequencer for the dehaze pipeline: streams one frame, pads it with flush pixels, waits for the drain, pulses done.
// Latency: source pixel to dp_pixel is 1 cycle; done appears 1 cycle after the last pipeline output is sampled.
// Backpressure: s_ready is high only in STREAM; the datapath side is valid-only and cannot stall.
// Optional drain watchdog is built when SEQ_WATCHDOG_EN is defined; otherwise timeout is tied low.
module dehaze_frame_sequencer #(
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int FLUSH_MAX   = 2*IMG_WIDTH+16,
    parameter int CNT_W       = 20,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      s_pixel,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [23:0]      dp_pixel,
    output logic             dp_valid,
    input  logic             dp_out_valid,
    output logic             sof,
    output logic             eof,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int               N_PIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] ALL_PIX  = CNT_W'(N_PIX);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
    localparam int               FL_W     = $clog2(FLUSH_MAX + 2);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_MAX - 1);

    // Parameter sanity: the counters must hold N and the limits must be non-zero.
    if (FLUSH_MAX < 1) begin : g_bad_flush_max
        $error("FLUSH_MAX must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(N_PIX)) begin : g_bad_cnt_w
        $error("CNT_W too small for IMG_WIDTH*IMG_HEIGHT");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [FL_W-1:0]  fl_cnt;
    logic [CNT_W-1:0] nxt_row;
    logic [CNT_W-1:0] nxt_col;
    logic             out_hit;
    logic             out_full;

`ifdef SEQ_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign timeout = 1'b0;
`endif

    // Handshake and status decode straight from the state register.
    assign s_ready = (state == STREAM);
    assign busy    = (state != IDLE);

    // A pipeline output counts only while a frame is active and until N is reached;
    // out_full is true once the frame's last output has been (or is being) seen.
    assign out_hit  = dp_out_valid && (state != IDLE) && (out_cnt != ALL_PIX);
    assign out_full = (out_cnt == ALL_PIX) || (out_hit && (out_cnt == LAST_PIX));

    // Frame FSM with all registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            fl_cnt   <= '0;
            nxt_row  <= '0;
            nxt_col  <= '0;
            dp_pixel <= '0;
            dp_valid <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            row      <= '0;
            col      <= '0;
            done     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt   <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            dp_valid <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            done     <= 1'b0;
            if (out_hit) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        fl_cnt  <= '0;
                        nxt_row <= '0;
                        nxt_col <= '0;
                        row     <= '0;
                        col     <= '0;
`ifdef SEQ_WATCHDOG_EN
                        wd_cnt  <= '0;
                        timeout <= 1'b0;
`endif
                    end
                end
                STREAM: begin
                    // s_ready is high throughout STREAM, so s_valid alone means accept.
                    if (s_valid) begin
                        dp_pixel <= s_pixel;
                        dp_valid <= 1'b1;
                        sof      <= (in_cnt == '0);
                        eof      <= (in_cnt == LAST_PIX);
                        row      <= nxt_row;
                        col      <= nxt_col;
                        in_cnt   <= in_cnt + CNT_W'(1);
                        if (nxt_col == LAST_COL) begin
                            nxt_col <= '0;
                            nxt_row <= nxt_row + CNT_W'(1);
                        end else begin
                            nxt_col <= nxt_col + CNT_W'(1);
                        end
                        if (in_cnt == LAST_PIX) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Completion beats the flush limit; dp_pixel holds the last pixel as padding.
                    if (out_full) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        dp_valid <= 1'b1;
                        fl_cnt   <= fl_cnt + FL_W'(1);
                        if (fl_cnt == FL_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_full) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dehaze_frame_sequencer.sv
`timescale 1ns/1ps
module tb_dehaze_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [23:0]   s_pixel = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [23:0]   dp_pixel;
    logic          dp_valid;
    logic          dp_out_valid;
    logic          sof, eof;
    logic [CW-1:0] row, col;
    logic          busy, done, timeout;

    always #5 clk = ~clk;

    dehaze_frame_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_MAX(10), .CNT_W(CW), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .dp_pixel(dp_pixel), .dp_valid(dp_valid), .dp_out_valid(dp_out_valid),
        .sof(sof), .eof(eof), .row(row), .col(col),
        .busy(busy), .done(done), .timeout(timeout)
    );

    // Datapath model: dp_out_valid follows dp_valid after lat cycles.
    int          lat = 5;
    logic        pipe_en = 1'b1;
    logic        inj = 1'b0;
    logic [63:0] sh = '0;
    always @(posedge clk) begin
        if (rst) sh <= '0;
        else     sh <= {sh[62:0], dp_valid === 1'b1};
    end
    assign dp_out_valid = (pipe_en && sh[lat-1]) || inj;

    // Bench-side bookkeeping of cycles, accepts and counted pipeline outputs.
    int   cyc = 0;
    int   tb_outs = 0;
    int   last_out_cyc = -1;
    int   last_beat_cyc = 0;
    int   done_cnt = 0;
    logic acc_last = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_last <= s_valid && (s_ready === 1'b1);
        if (rst) tb_outs <= 0;
        else if (start && busy === 1'b0) tb_outs <= 0;
        else if (dp_out_valid && busy === 1'b1) begin
            tb_outs      <= tb_outs + 1;
            last_out_cyc <= cyc + 1;
        end
    end

    typedef struct packed {
        logic [23:0]   pix;
        logic          sof;
        logic          eof;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic          flush;
    } beat_t;
    typedef struct packed {
        logic        to;
        logic [31:0] outs;
        logic [31:0] gap;
    } done_t;

    beat_t exp_q[$];
    done_t done_q[$];
    beat_t e;
    done_t d;

    int n_pass = 0;
    int n_total = 0;

    logic [23:0] pix_tab [8] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0,
                                 24'hD0E0F0, 24'h123456, 24'h789ABC, 24'hDEF012};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a done pulse.
    always @(negedge clk) begin
        if (dp_valid === 1'b1) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.flush ? "flush_beat" : "frame_beat",
                    {dp_pixel, sof, eof, row, col}, {e.pix, e.sof, e.eof, e.row, e.col});
                if (!e.flush) chk("beat_latency", acc_last, 1);
            end
            last_beat_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_expected", done_q.size() != 0, 1);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                chk("done_busy", busy, 0);
                chk("done_timeout_flag", timeout, d.to);
                chk("done_out_count", tb_outs, d.outs);
                if (d.outs != 0) chk("done_after_last_out", last_out_cyc, cyc);
                chk("done_gap_after_last_beat", cyc - last_beat_cyc, d.gap);
            end
        end
    end

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{pix_tab[i], i == 0, i == W*H-1, CW'(i / W), CW'(i % W), 1'b0});
    endtask

    task automatic push_frame(input int n_flush, input int gap, input logic to, input int outs);
        push_beats(W*H);
        for (int j = 0; j < n_flush; j++)
            exp_q.push_back('{pix_tab[W*H-1], 1'b0, 1'b0, CW'(H-1), CW'(W-1), 1'b1});
        done_q.push_back('{to, 32'(outs), 32'(gap)});
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle, input bit start_mid);
        for (int i = 0; i < n; i++) begin
            s_pixel = pix_tab[i];
            s_valid = 1'b1;
            start   = start_mid && (i == 3);
            @(posedge clk); #1;
            start = 1'b0;
            if (toggle) begin
                s_valid = 1'b0;
                s_pixel = 24'hBAD000;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int c;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("done_seen", done_cnt != d0, 1);
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {s_ready, dp_pixel, dp_valid, sof, eof, row, col, busy, done, timeout}, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int d_before;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

        // Continuous source, 5-cycle pipeline: 5 flush beats, done right after the 8th output.
        lat = 5;
        push_frame(5, 1, 1'b0, 8);
        start_frame();
        feed(8, 1'b0, 1'b0);
        wait_done(200);

        // Source toggling 1/0.
        push_frame(5, 1, 1'b0, 8);
        start_frame();
        feed(8, 1'b1, 1'b0);
        wait_done(200);

        // 30-cycle pipeline: flush limit of 10 is hit, DRAIN until the 8th output.
        lat = 30;
        push_frame(10, 21, 1'b0, 8);
        start_frame();
        feed(8, 1'b0, 1'b0);
        wait_done(200);

        // Reset while the 5th pixel is being accepted.
        lat = 5;
        push_beats(4);
        start_frame();
        feed(4, 1'b0, 1'b0);
        d_before = done_cnt;
        s_pixel  = pix_tab[4];
        s_valid  = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        chk_reset_vals("mid_frame_rst");
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt, d_before);
        push_frame(5, 1, 1'b0, 8);
        start_frame();
        feed(8, 1'b0, 1'b0);
        wait_done(200);

        // dp_out_valid while idle and start during STREAM are both ignored.
        inj = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inj = 1'b0;
        push_frame(5, 1, 1'b0, 8);
        start_frame();
        feed(8, 1'b0, 1'b1);
        wait_done(200);

`ifdef SEQ_WATCHDOG_EN
        // Silent datapath: 10 flush beats, 16 DRAIN cycles, then timeout with done.
        pipe_en = 1'b0;
        push_frame(10, 16, 1'b1, 0);
        start_frame();
        feed(8, 1'b0, 1'b0);
        wait_done(200);
        chk("timeout_sticky", timeout, 1);
        pipe_en = 1'b1;
        push_frame(5, 1, 1'b0, 8);
        start_frame();
        feed(8, 1'b0, 1'b0);
        wait_done(200);
`endif

        chk("beats_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
